// File: rtl/sh7034_sci_link.sv
// Clock-synchronous link partner for the SH7034 SCI (clocked mode, SCI is master), with byte FIFOs both ways.
// Optional feature: define SCI_LINK_TIMEOUT_EN to resync after a mid-byte SCK stall of TIMEOUT CE_R cycles.
module sh7034_sci_link #(
  parameter int FIFO_AW = 4
`ifdef SCI_LINK_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1023
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE_R,
  input  logic             SCK_I,
  input  logic             SDI,
  output logic             SDO,
  input  logic [7:0]       TX_DATA,
  input  logic             TX_WR,
  output logic             TX_FULL,
  output logic [FIFO_AW:0] TX_LEVEL,
  output logic [7:0]       RX_DATA,
  input  logic             RX_RD,
  output logic             RX_EMPTY,
  output logic [FIFO_AW:0] RX_LEVEL,
  output logic             BYTE_DONE,
  output logic             RX_OVF,
  output logic             TX_UNF,
  output logic             RESYNC,
  input  logic             FLAG_CLR
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

  logic               r_sck_old;
  logic [2:0]         r_bcnt;
  logic [7:0]         r_tsr;
  logic [7:0]         r_rsr;
  logic               r_sdo;
  logic               r_byte_done;
  logic               r_rx_ovf;
  logic               r_tx_unf;
  logic               r_resync;

  logic [7:0]         r_tx_mem [DEPTH];
  logic [FIFO_AW-1:0] r_tx_wp;
  logic [FIFO_AW-1:0] r_tx_rp;
  logic [FIFO_AW:0]   r_tx_lvl;
  logic [7:0]         r_rx_mem [DEPTH];
  logic [FIFO_AW-1:0] r_rx_wp;
  logic [FIFO_AW-1:0] r_rx_rp;
  logic [FIFO_AW:0]   r_rx_lvl;

  logic       w_fall;
  logic       w_rise;
  logic       w_byte_start;
  logic       w_tx_empty;
  logic       w_tx_full;
  logic       w_tx_pop;
  logic       w_tx_push;
  logic [7:0] w_tsr_load;
  logic [7:0] w_rsr_next;
  logic       w_rx_empty;
  logic       w_rx_full;
  logic       w_rx_done;
  logic       w_rx_pop;
  logic       w_rx_push;
  logic       w_rx_drop;
  logic       w_timeout;

  assign w_fall       = CE_R & r_sck_old & ~SCK_I;
  assign w_rise       = CE_R & ~r_sck_old & SCK_I;
  assign w_byte_start = w_fall & (r_bcnt == 3'd0);

  assign w_tx_empty = (r_tx_lvl == '0);
  assign w_tx_full  = (r_tx_lvl == FULL_LVL);
  assign w_tx_pop   = w_byte_start & ~w_tx_empty;
  assign w_tx_push  = CE_R & TX_WR & (~w_tx_full | w_tx_pop);
  assign w_tsr_load = w_tx_empty ? 8'hFF : r_tx_mem[r_tx_rp];

  assign w_rsr_next = {SDI, r_rsr[7:1]};
  assign w_rx_empty = (r_rx_lvl == '0);
  assign w_rx_full  = (r_rx_lvl == FULL_LVL);
  assign w_rx_done  = w_rise & (r_bcnt == 3'd7);
  assign w_rx_pop   = CE_R & RX_RD & ~w_rx_empty;
  // A full RX FIFO still takes the byte when the host frees a slot in the same cycle.
  assign w_rx_push  = w_rx_done & (~w_rx_full | w_rx_pop);
  assign w_rx_drop  = w_rx_done & w_rx_full & ~w_rx_pop;

`ifdef SCI_LINK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;

  assign w_timeout = CE_R & (r_bcnt != 3'd0) & ~w_fall & ~w_rise & (r_to_cnt == TO_W'(TIMEOUT));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_to_cnt <= '0;
    end else if (CE_R) begin
      if (w_fall || w_rise || (r_bcnt == 3'd0) || w_timeout) r_to_cnt <= '0;
      else                                                    r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sck_old   <= 1'b1;
      r_bcnt      <= 3'd0;
      r_tsr       <= 8'hFF;
      r_rsr       <= 8'hFF;
      r_sdo       <= 1'b1;
      r_byte_done <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_tx_unf    <= 1'b0;
      r_resync    <= 1'b0;
    end else if (CE_R) begin
      r_sck_old   <= SCK_I;
      r_byte_done <= w_rx_done;
      if (w_timeout) begin
        r_bcnt <= 3'd0;
        r_tsr  <= 8'hFF;
        r_rsr  <= 8'hFF;
        r_sdo  <= 1'b1;
      end else begin
        if (w_byte_start) begin
          r_tsr <= w_tsr_load;
          r_sdo <= w_tsr_load[0];
        end else if (w_fall) begin
          r_sdo <= r_tsr[r_bcnt];
        end
        if (w_rise) begin
          r_rsr  <= w_rsr_next;
          r_bcnt <= r_bcnt + 3'd1;
        end
      end
      // A set in the same cycle as FLAG_CLR wins.
      r_rx_ovf <= w_rx_drop | (r_rx_ovf & ~FLAG_CLR);
      r_tx_unf <= (w_byte_start & w_tx_empty) | (r_tx_unf & ~FLAG_CLR);
      r_resync <= w_timeout | (r_resync & ~FLAG_CLR);
    end
  end

  // NOTE: FIFO storage has no reset; RX_DATA is masked while empty so stale bytes never show.
  always_ff @(posedge CLK) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= TX_DATA;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= w_rsr_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_lvl <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_lvl <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      r_tx_lvl <= r_tx_lvl + (FIFO_AW + 1)'(w_tx_push) - (FIFO_AW + 1)'(w_tx_pop);
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      r_rx_lvl <= r_rx_lvl + (FIFO_AW + 1)'(w_rx_push) - (FIFO_AW + 1)'(w_rx_pop);
    end
  end

  assign SDO       = r_sdo;
  assign TX_FULL   = w_tx_full;
  assign TX_LEVEL  = r_tx_lvl;
  assign RX_DATA   = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
  assign RX_EMPTY  = w_rx_empty;
  assign RX_LEVEL  = r_rx_lvl;
  assign BYTE_DONE = r_byte_done;
  assign RX_OVF    = r_rx_ovf;
  assign TX_UNF    = r_tx_unf;
  assign RESYNC    = r_resync;

endmodule

// File: tb/tb_sh7034_sci_link.sv
// Self-checking bench for sh7034_sci_link: bench acts as the SCI master and the host.
// Expectations come from a bit-level scoreboard of both FIFOs; honours SCI_LINK_TIMEOUT_EN.
module tb_sh7034_sci_link;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE_R = 1'b1;
  logic       SCK_I = 1'b1;
  logic       SDI = 1'b1;
  logic       SDO;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_WR = 1'b0;
  logic       TX_FULL;
  logic [4:0] TX_LEVEL;
  logic [7:0] RX_DATA;
  logic       RX_RD = 1'b0;
  logic       RX_EMPTY;
  logic [4:0] RX_LEVEL;
  logic       BYTE_DONE;
  logic       RX_OVF;
  logic       TX_UNF;
  logic       RESYNC;
  logic       FLAG_CLR = 1'b0;

  sh7034_sci_link dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .SCK_I(SCK_I), .SDI(SDI), .SDO(SDO),
    .TX_DATA(TX_DATA), .TX_WR(TX_WR), .TX_FULL(TX_FULL), .TX_LEVEL(TX_LEVEL),
    .RX_DATA(RX_DATA), .RX_RD(RX_RD), .RX_EMPTY(RX_EMPTY), .RX_LEVEL(RX_LEVEL),
    .BYTE_DONE(BYTE_DONE), .RX_OVF(RX_OVF), .TX_UNF(TX_UNF), .RESYNC(RESYNC),
    .FLAG_CLR(FLAG_CLR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int bd_cnt = 0;

  // Scoreboard and master-side model state.
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] m_tsr = 8'hFF;
  logic [7:0] m_rsr = 8'hFF;
  logic [7:0] m_cap = 8'hFF;
  int         m_cnt = 0;
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;
  logic       exp_resync = 1'b0;

  localparam logic [24:0] RESET_VEC = {1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 4'b0000, 8'h00};

  always @(negedge CLK) if (BYTE_DONE === 1'b1) bd_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [24:0] out_vec();
    return {SDO, TX_FULL, TX_LEVEL, RX_EMPTY, RX_LEVEL, BYTE_DONE, RX_OVF, TX_UNF, RESYNC, RX_DATA};
  endfunction

  task automatic model_reset();
    exp_tx_q.delete();
    exp_rx_q.delete();
    m_tsr = 8'hFF; m_rsr = 8'hFF; m_cap = 8'hFF; m_cnt = 0;
    exp_ovf = 1'b0; exp_unf = 1'b0; exp_resync = 1'b0;
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge CLK);
    TX_DATA = d;
    TX_WR = 1'b1;
    if (exp_tx_q.size() < 16) exp_tx_q.push_back(d);
    @(negedge CLK);
    TX_WR = 1'b0;
  endtask

  task automatic flag_clr();
    @(negedge CLK);
    FLAG_CLR = 1'b1;
    @(negedge CLK);
    FLAG_CLR = 1'b0;
    exp_ovf = 1'b0; exp_unf = 1'b0; exp_resync = 1'b0;
  endtask

  // One SCK period as the SCI drives it; optionally asserts TX_WR with the falling edge.
  task automatic master_bit(input logic sdi, input logic do_wr, input logic [7:0] wr_data);
    @(negedge CLK);
    SCK_I = 1'b0;
    SDI = sdi;
    if (do_wr) begin
      TX_DATA = wr_data;
      TX_WR = 1'b1;
    end
    if (m_cnt == 0) begin
      if (exp_tx_q.size() > 0) m_tsr = exp_tx_q.pop_front();
      else begin
        m_tsr = 8'hFF;
        exp_unf = 1'b1;
      end
      if (do_wr) exp_tx_q.push_back(wr_data);
    end else if (do_wr && exp_tx_q.size() < 16) begin
      exp_tx_q.push_back(wr_data);
    end
    @(negedge CLK);
    TX_WR = 1'b0;
    repeat (2) @(negedge CLK);
    m_cap[m_cnt] = SDO;
    SCK_I = 1'b1;
    m_rsr = {sdi, m_rsr[7:1]};
    if (m_cnt == 7) begin
      m_cnt = 0;
      if (exp_rx_q.size() < 16) exp_rx_q.push_back(m_rsr);
      else exp_ovf = 1'b1;
      checks++;
      if (m_cap !== m_tsr) begin
        errors++;
        $display("FAIL sdo_byte: got %h need %h", m_cap, m_tsr);
      end
    end else begin
      m_cnt++;
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic master_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) master_bit(b[i], 1'b0, 8'h00);
  endtask

  task automatic read_rx();
    logic [7:0] exp;
    @(negedge CLK);
    checks++;
    if (exp_rx_q.size() == 0) begin
      errors++;
      $display("FAIL rx_read: got %h need no pending byte", RX_DATA);
    end else begin
      exp = exp_rx_q.pop_front();
      if (RX_EMPTY !== 1'b0 || RX_DATA !== exp) begin
        errors++;
        $display("FAIL rx_read: got %h empty=%b need %h empty=0", RX_DATA, RX_EMPTY, exp);
      end
    end
    RX_RD = 1'b1;
    @(negedge CLK);
    RX_RD = 1'b0;
  endtask

  task automatic check_flags(input string name);
    checks++;
    if ({RX_OVF, TX_UNF, RESYNC} !== {exp_ovf, exp_unf, exp_resync}) begin
      errors++;
      $display("FAIL %s: got ovf/unf/resync %b%b%b need %b%b%b", name,
               RX_OVF, TX_UNF, RESYNC, exp_ovf, exp_unf, exp_resync);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_during: got %h need %h", out_vec(), RESET_VEC);
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_after: got %h need %h", out_vec(), RESET_VEC);
    end
    model_reset();
  endtask

  task automatic test_duplex();
    int bd0;
    bd0 = bd_cnt;
    write_tx(8'hA5);
    write_tx(8'h3C);
    master_byte(8'h5A);
    master_byte(8'hC3);
    checks++;
    if (bd_cnt - bd0 != 2) begin
      errors++;
      $display("FAIL byte_done_count: got %0d need 2", bd_cnt - bd0);
    end
    checks++;
    if (TX_LEVEL !== 5'd0) begin
      errors++;
      $display("FAIL duplex_tx_level: got %0d need 0", TX_LEVEL);
    end
    read_rx();
    read_rx();
    check_flags("duplex_flags");
  endtask

  task automatic test_underflow();
    flag_clr();
    master_byte(8'h33);
    check_flags("underflow_set");
    flag_clr();
    check_flags("underflow_clr");
    read_rx();
  endtask

  task automatic test_tx_full();
    logic [7:0] b;
    for (int i = 0; i < 16; i++) write_tx(8'h40 + 8'(i));
    checks++;
    if (TX_FULL !== 1'b1 || TX_LEVEL !== 5'd16) begin
      errors++;
      $display("FAIL tx_fill: got full=%b level=%0d need full=1 level=16", TX_FULL, TX_LEVEL);
    end
    write_tx(8'hEE);
    checks++;
    if (TX_LEVEL !== 5'd16) begin
      errors++;
      $display("FAIL tx_write_when_full: got level=%0d need 16", TX_LEVEL);
    end
    b = 8'hB6;
    master_bit(b[0], 1'b1, 8'h77);
    checks++;
    if (TX_LEVEL !== 5'd16 || TX_FULL !== 1'b1) begin
      errors++;
      $display("FAIL tx_write_with_pop: got level=%0d full=%b need 16 1", TX_LEVEL, TX_FULL);
    end
    for (int i = 1; i < 8; i++) master_bit(b[i], 1'b0, 8'h00);
    read_rx();
    for (int i = 0; i < 16; i++) begin
      master_byte(8'h90 + 8'(i));
      read_rx();
    end
    checks++;
    if (TX_LEVEL !== 5'd0 || TX_FULL !== 1'b0) begin
      errors++;
      $display("FAIL tx_drain: got level=%0d full=%b need 0 0", TX_LEVEL, TX_FULL);
    end
    check_flags("tx_full_flags");
  endtask

  task automatic test_rx_overflow();
    flag_clr();
    for (int i = 0; i <= 16; i++) master_byte(8'(i));
    checks++;
    if (RX_LEVEL !== 5'd16) begin
      errors++;
      $display("FAIL rx_level_full: got %0d need 16", RX_LEVEL);
    end
    check_flags("rx_overflow_flags");
    for (int i = 0; i < 16; i++) read_rx();
    checks++;
    if (RX_EMPTY !== 1'b1 || RX_LEVEL !== 5'd0) begin
      errors++;
      $display("FAIL rx_drained: got empty=%b level=%0d need 1 0", RX_EMPTY, RX_LEVEL);
    end
  endtask

  task automatic test_timeout();
    int n;
    flag_clr();
    master_bit(1'b1, 1'b0, 8'h00);
    master_bit(1'b0, 1'b0, 8'h00);
    master_bit(1'b1, 1'b0, 8'h00);
    repeat (1100) @(negedge CLK);
`ifdef SCI_LINK_TIMEOUT_EN
    m_cnt = 0;
    m_rsr = 8'hFF;
    exp_resync = 1'b1;
    checks++;
    if (SDO !== 1'b1) begin
      errors++;
      $display("FAIL resync_sdo: got %b need 1", SDO);
    end
`endif
    master_byte(8'h81);
    check_flags("timeout_flags");
    checks++;
    if (RX_LEVEL !== 5'(exp_rx_q.size())) begin
      errors++;
      $display("FAIL timeout_rx_level: got %0d need %0d", RX_LEVEL, exp_rx_q.size());
    end
    n = exp_rx_q.size();
    for (int i = 0; i < n; i++) read_rx();
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b;
    write_tx(8'h12);
    master_byte(8'h55);
    write_tx(8'h9A);
    b = 8'hF0;
    for (int i = 0; i < 4; i++) master_bit(b[i], 1'b0, 8'h00);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_mid_byte: got %h need %h", out_vec(), RESET_VEC);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_reset();
    master_byte(8'h96);
    read_rx();
    checks++;
    if (RX_EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_empty: got %b need 1", RX_EMPTY);
    end
    check_flags("post_reset_flags");
  endtask

  initial begin
    test_reset();
    test_duplex();
    test_underflow();
    test_tx_full();
    test_rx_overflow();
    test_timeout();
    test_reset_mid_byte();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
